// File: rtl/posit_accum_seq.sv
// posit_accum_seq
//   Reduces a burst of posits (in_last marks the final word) to a single posit sum
//   by issuing operand pairs to an external start/done posit adder. Returned partial
//   sums are recycled into the operand buffer, so several adds can be in flight.
//   Optional feature macro: POSIT_ACC_ZERO_SKIP_EN -- when defined, accepted zero
//   words are not written to the operand buffer (in_last is still honoured) and an
//   all-zero burst reduces to a zero sum without any add.
module posit_accum_seq #(
    parameter int N       = 32,
    parameter int es      = 2,
    parameter int DEPTH   = 8,
    parameter int ADD_LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         add_start,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    input  logic         add_done,
    input  logic [N-1:0] add_result,
    output logic         sum_valid,
    input  logic         sum_ready,
    output logic [N-1:0] sum_data,
    output logic         sum_inf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CW:0]   DEPTH_W    = (CW + 1)'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ADD_LAT - 1);
    localparam logic [N-1:0]  NAR        = {1'b1, {(N - 1){1'b0}}};

    if (DEPTH < 4 || ADD_LAT < 1 || es < 0 || es > N - 3) begin : g_bad_param
        $error("posit_accum_seq: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Circular pointer advance by 0..2 entries; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] inc);
        logic [PW+1:0] sum_v;
        sum_v = {2'b00, ptr} + {{PW{1'b0}}, inc};
        return (sum_v >= (PW + 2)'(DEPTH)) ? PW'(sum_v - (PW + 2)'(DEPTH)) : PW'(sum_v);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [FW-1:0]   flush_cnt_r;
    logic [CW-1:0]   occ_r;
    logic [CW-1:0]   out_r;
    logic            last_seen_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [N-1:0]    buf_r [DEPTH];

    logic            in_ready_r;
    logic            add_start_r;
    logic [N-1:0]    add_in1_r;
    logic [N-1:0]    add_in2_r;
    logic            sum_valid_r;
    logic [N-1:0]    sum_data_r;

    logic            in_fire_s;
    logic            in_we_s;
    logic            ret_we_s;
    logic            issue_s;
    logic            fin_pop_s;
    logic            fin_zero_s;
    logic            sum_take_s;
    logic [CW-1:0]   occ_nxt_s;
    logic [CW-1:0]   out_nxt_s;
    logic            last_nxt_s;
    logic [PW-1:0]   in_wr_ptr_s;
    logic [PW-1:0]   wr_ptr_nxt_s;
    logic [PW-1:0]   rd_ptr1_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic            in_ready_nxt_s;
    logic            sum_valid_nxt_s;
    logic            add_start_nxt_s;

    // Per-cycle buffer events: input write, adder return, pair issue, final pop.
    always_comb begin
        in_fire_s  = in_valid & in_ready_r;
        sum_take_s = sum_valid_r & sum_ready;
        ret_we_s   = 1'b0;
        in_we_s    = 1'b0;
        issue_s    = 1'b0;
        fin_pop_s  = 1'b0;
        fin_zero_s = 1'b0;
        if (state_r == ST_ACCUM) begin
            // Returns with nothing outstanding are stale results and are dropped.
            ret_we_s  = add_done & (out_r != {CW{1'b0}});
`ifdef POSIT_ACC_ZERO_SKIP_EN
            in_we_s    = in_fire_s & (in_data != {N{1'b0}});
            fin_zero_s = last_seen_r & (out_r == {CW{1'b0}}) & (occ_r == {CW{1'b0}});
`else
            in_we_s    = in_fire_s;
            fin_zero_s = 1'b0;
`endif
            // Issue decision uses occupancy before this cycle's writes.
            issue_s   = (occ_r >= CW'(2));
            fin_pop_s = last_seen_r & (out_r == {CW{1'b0}}) & (occ_r == CW'(1));
        end else begin
            ret_we_s   = 1'b0;
            in_we_s    = 1'b0;
            issue_s    = 1'b0;
            fin_pop_s  = 1'b0;
            fin_zero_s = 1'b0;
        end
    end

    // Next occupancy, outstanding count, pointers and burst-end flag.
    always_comb begin
        occ_nxt_s    = occ_r + CW'(ret_we_s) + CW'(in_we_s)
                       - (issue_s ? CW'(2) : CW'(0)) - CW'(fin_pop_s);
        out_nxt_s    = out_r + CW'(issue_s) - CW'(ret_we_s);
        // The adder return takes the first free slot, the input word the next one.
        in_wr_ptr_s  = ret_we_s ? ptr_add(wr_ptr_r, 2'd1) : wr_ptr_r;
        wr_ptr_nxt_s = ptr_add(wr_ptr_r, {1'b0, ret_we_s} + {1'b0, in_we_s});
        rd_ptr1_s    = ptr_add(rd_ptr_r, 2'd1);
        if (issue_s) begin
            rd_ptr_nxt_s = ptr_add(rd_ptr_r, 2'd2);
        end else if (fin_pop_s) begin
            rd_ptr_nxt_s = rd_ptr1_s;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (state_r == ST_OUT && sum_take_s) begin
            last_nxt_s = 1'b0;
        end else if (in_fire_s && in_last) begin
            last_nxt_s = 1'b1;
        end else begin
            last_nxt_s = last_seen_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FLUSH: state_nxt_s = (flush_cnt_r == FLUSH_LAST) ? ST_ACCUM : ST_FLUSH;
            ST_ACCUM: state_nxt_s = (fin_pop_s | fin_zero_s) ? ST_OUT : ST_ACCUM;
            ST_OUT:   state_nxt_s = sum_take_s ? ST_ACCUM : ST_OUT;
            default:  state_nxt_s = ST_FLUSH;
        endcase
    end

    // Output decode from next-cycle state so that the handshake outputs are registered.
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == ST_ACCUM) & ~last_nxt_s &
                          (({1'b0, occ_nxt_s} + {1'b0, out_nxt_s}) < DEPTH_W);
        sum_valid_nxt_s = (state_nxt_s == ST_OUT);
        add_start_nxt_s = issue_s;
    end

    // State register and adder-pipeline flush counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= (state_r == ST_FLUSH) ? flush_cnt_r + FW'(1) : {FW{1'b0}};
        end
    end

    // Buffer bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_r       <= {CW{1'b0}};
            out_r       <= {CW{1'b0}};
            last_seen_r <= 1'b0;
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            in_ready_r  <= 1'b0;
            add_start_r <= 1'b0;
            add_in1_r   <= {N{1'b0}};
            add_in2_r   <= {N{1'b0}};
            sum_valid_r <= 1'b0;
            sum_data_r  <= {N{1'b0}};
        end else begin
            occ_r       <= occ_nxt_s;
            out_r       <= out_nxt_s;
            last_seen_r <= last_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            add_start_r <= add_start_nxt_s;
            sum_valid_r <= sum_valid_nxt_s;
            if (issue_s) begin
                add_in1_r <= buf_r[rd_ptr_r];
                add_in2_r <= buf_r[rd_ptr1_s];
            end else begin
                add_in1_r <= add_in1_r;
                add_in2_r <= add_in2_r;
            end
            if (fin_pop_s) begin
                sum_data_r <= buf_r[rd_ptr_r];
            end else if (fin_zero_s) begin
                sum_data_r <= {N{1'b0}};
            end else begin
                sum_data_r <= sum_data_r;
            end
        end
    end

    // Operand buffer storage; contents are meaningless outside occupied slots.
    always_ff @(posedge clk) begin
        if (ret_we_s) begin
            buf_r[wr_ptr_r] <= add_result;
        end else begin
            buf_r[wr_ptr_r] <= buf_r[wr_ptr_r];
        end
        if (in_we_s) begin
            buf_r[in_wr_ptr_s] <= in_data;
        end else begin
            buf_r[in_wr_ptr_s] <= buf_r[in_wr_ptr_s];
        end
    end

    assign in_ready  = in_ready_r;
    assign add_start = add_start_r;
    assign add_in1   = add_in1_r;
    assign add_in2   = add_in2_r;
    assign sum_valid = sum_valid_r;
    assign sum_data  = sum_data_r;
    assign sum_inf   = (sum_data_r == NAR);

endmodule

// File: tb/tb_posit_accum_seq.sv
// Directed testbench for posit_accum_seq with a behavioural posit32/es=2 adder
// that supports small non-negative integers and NaR.
module tb_posit_accum_seq;

    localparam int ADD_LAT = 4;
    localparam logic [31:0] NAR = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        add_start;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic        add_done;
    logic [31:0] add_result;
    logic        sum_valid;
    logic        sum_ready;
    logic [31:0] sum_data;
    logic        sum_inf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    posit_accum_seq #(.N(32), .es(2), .DEPTH(8), .ADD_LAT(ADD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .add_start  (add_start),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_done   (add_done),
        .add_result (add_result),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data),
        .sum_inf    (sum_inf)
    );

    // Encode a small non-negative integer as posit32, es=2 (useed = 16).
    function automatic logic [31:0] enc(input int v);
        logic [31:0] r;
        int p, k, e, idx;
        r = 32'h0;
        if (v <= 0) return r;
        p = 0;
        for (int b = 0; b < 31; b++) if (v[b]) p = b;
        k = p / 4;
        e = p % 4;
        idx = 30;
        for (int i = 0; i <= k; i++) begin r[idx] = 1'b1; idx--; end
        r[idx] = 1'b0; idx--;
        r[idx] = e[1]; idx--;
        r[idx] = e[0]; idx--;
        for (int j = p - 1; j >= 0; j--) begin r[idx] = v[j]; idx--; end
        return r;
    endfunction

    function automatic int dec(input logic [31:0] p);
        for (int v = 0; v < 256; v++) if (enc(v) == p) return v;
        return -1;
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR) return NAR;
        return enc(dec(a) + dec(b));
    endfunction

    // Adder model: result appears ADD_LAT cycles after the start pulse is sampled.
    logic [ADD_LAT-1:0] pipe_v = '0;
    logic [31:0]        pipe_d [0:ADD_LAT-1];
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[ADD_LAT-2:0], add_start};
        pipe_d[0] <= model_add(add_in1, add_in2);
        for (int i = 1; i < ADD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign add_done   = pipe_v[ADD_LAT-1];
    assign add_result = pipe_d[ADD_LAT-1];

    // Monitors: issued pulses with their operands, and sum_valid cycles.
    int          start_cnt = 0;
    int          sv_cnt = 0;
    logic [31:0] op1_log [0:255];
    logic [31:0] op2_log [0:255];
    always @(posedge clk) begin
        if (add_start) begin
            op1_log[start_cnt[7:0]] <= add_in1;
            op2_log[start_cnt[7:0]] <= add_in2;
            start_cnt <= start_cnt + 1;
        end
        if (sum_valid) sv_cnt <= sv_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 200;
        while (in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("send_accept", 32'(budget > 0), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic wait_sum(input string tag);
        int budget;
        budget = 300;
        while (sum_valid !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({tag, "_timeout"}, 32'(budget > 0), 32'd1);
    endtask

    task automatic take_sum(input string tag, input logic [31:0] exp);
        wait_sum(tag);
        chk({tag, "_data"}, sum_data, exp);
        chk({tag, "_inf"}, 32'(sum_inf), 32'(exp == NAR));
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(sum_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // Release reset at a negedge and check the ADD_LAT-cycle flush window.
    task automatic release_and_flush(input string tag);
        reset = 1'b0;
        chk({tag, "_flush0"}, 32'(in_ready), 32'd0);
        for (int i = 1; i < ADD_LAT; i++) begin
            @(negedge clk);
            chk({tag, "_flush"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    int base;
    int sv_base;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        sum_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum_data",  sum_data,       32'h0);
        chk("rst_sum_inf",   32'(sum_inf),   32'd0);
        chk("rst_add_in1",   add_in1,        32'h0);
        chk("rst_add_in2",   add_in2,        32'h0);
        release_and_flush("rst");

        // 1.0 + 2.0 + 3.0 + 4.0 = 10.0 with exactly three adds
        base = start_cnt;
        send_word(32'h40000000, 1'b0);
        send_word(32'h48000000, 1'b0);
        send_word(32'h4C000000, 1'b0);
        send_word(32'h50000000, 1'b1);
        take_sum("sum10", 32'h5A000000);
        chk("sum10_adds", 32'(start_cnt - base), 32'd3);
        chk("sum10_op1_first", op1_log[base[7:0]], 32'h40000000);
        chk("sum10_op2_first", op2_log[base[7:0]], 32'h48000000);
        chk("sum10_op1_second", op1_log[8'(base + 1)], 32'h4C000000);
        chk("sum10_op2_second", op2_log[8'(base + 1)], 32'h50000000);

        // Single-word burst: no add, sum_valid two cycles after the accept cycle
        base = start_cnt;
        send_word(32'h48000000, 1'b1);
        chk("single_lat1", 32'(sum_valid), 32'd0);
        @(negedge clk);
        chk("single_lat2", 32'(sum_valid), 32'd1);
        take_sum("single", 32'h48000000);
        chk("single_adds", 32'(start_cnt - base), 32'd0);

        // NaR propagates
        send_word(32'h40000000, 1'b0);
        send_word(NAR,          1'b0);
        send_word(32'h40000000, 1'b0);
        send_word(32'h40000000, 1'b1);
        take_sum("nar", NAR);

        // 16 x 1.0, sum held for 20 cycles while another word waits
        base = start_cnt;
        for (int i = 0; i < 16; i++) send_word(32'h40000000, i == 15);
        wait_sum("sum16");
        in_valid = 1'b1;
        in_data  = 32'h48000000;
        in_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("sum16_hold_valid", 32'(sum_valid), 32'd1);
            chk("sum16_hold_data",  sum_data,       32'h60000000);
            chk("sum16_backpress",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        chk("sum16_adds", 32'(start_cnt - base), 32'd15);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk("sum16_valid_drop", 32'(sum_valid), 32'd0);
        chk("sum16_ready_back", 32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
        take_sum("after16", 32'h48000000);

        // Reset mid-burst: no sum, flush window, then a clean burst
        sv_base = sv_cnt;
        send_word(32'h40000000, 1'b0);
        send_word(32'h40000000, 1'b0);
        send_word(32'h40000000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        release_and_flush("midrst");
        chk("midrst_no_sum", 32'(sv_cnt - sv_base), 32'd0);
        send_word(32'h40000000, 1'b0);
        send_word(32'h40000000, 1'b1);
        take_sum("midrst_next", 32'h48000000);

        // All-zero burst
        base = start_cnt;
        send_word(32'h0, 1'b0);
        send_word(32'h0, 1'b0);
        send_word(32'h0, 1'b1);
        take_sum("zeros", 32'h0);
`ifdef POSIT_ACC_ZERO_SKIP_EN
        chk("zeros_adds", 32'(start_cnt - base), 32'd0);
`else
        chk("zeros_adds", 32'(start_cnt - base), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
